// File: rtl/kds_multilane_if.sv
// Kernel data shifter bus: input column handshake, per-lane load mask,
// step/clear controls and the registered lane outputs.
interface kds_multilane_if #(
   parameter int DATA_WIDTH  = 16,
   parameter int KERNEL_SIZE = 3,
   parameter int NB_LANES    = 12,
   parameter int DEPTH       = 8
);
   localparam int COL_W = KERNEL_SIZE * DATA_WIDTH;
   localparam int ROT_W = $clog2(DEPTH);

   logic [COL_W-1:0]          in_data;
   logic                      in_valid;
   logic                      in_ready;
   logic [NB_LANES-1:0]       lane_load;
   logic                      advance;
   logic                      clear;
   logic [NB_LANES*COL_W-1:0] out_data;
   logic [NB_LANES-1:0]       out_valid;
   logic [ROT_W-1:0]          rot_count;
   logic                      rot_wrap;

   modport master (
      output in_data, in_valid, lane_load, advance, clear,
      input  in_ready, out_data, out_valid, rot_count, rot_wrap
   );

   modport slave (
      input  in_data, in_valid, lane_load, advance, clear,
      output in_ready, out_data, out_valid, rot_count, rot_wrap
   );
endinterface

// File: rtl/kds_multilane.sv
// Kernel data shifter: NB_LANES lanes of KERNEL_SIZE rows, each row a
// DEPTH-entry delay line. Every step each lane either loads the input
// column at its tail or recirculates its head back to the tail.
// DEPTH must be a power of two and at least 2 so rot_count wraps naturally.
module kds_multilane #(
   parameter int DATA_WIDTH  = 16,
   parameter int KERNEL_SIZE = 3,
   parameter int NB_LANES    = 12,
   parameter int DEPTH       = 8
) (
   input logic              clk,
   input logic              arst_in,
   kds_multilane_if.slave   bus
);
   localparam int ROT_W = $clog2(DEPTH);
   localparam int FILL_W = ROT_W + 1;
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DEPTH);
   localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1);

   typedef enum logic [1:0] {
      LANE_EMPTY   = 2'd0,
      LANE_FILLING = 2'd1,
      LANE_FULL    = 2'd2
   } lane_st_t;

   logic any_load_s;
   logic step_s;
   logic ready_s;

   logic [DATA_WIDTH-1:0] mem_q [NB_LANES][KERNEL_SIZE][DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [NB_LANES][KERNEL_SIZE][DEPTH];

   lane_st_t            lane_st_q [NB_LANES];
   logic [FILL_W-1:0]   fill_q    [NB_LANES];
   logic [NB_LANES-1:0] out_valid_q;

   logic [ROT_W-1:0] rot_count_q, rot_count_d;
   logic             rot_wrap_q,  rot_wrap_d;

   logic [NB_LANES*KERNEL_SIZE*DATA_WIDTH-1:0] out_data_s;

   // Step/ready decode; clear suppresses both, ready ignores in_valid.
   always_comb begin
      any_load_s = |bus.lane_load;
      step_s     = bus.advance & (~any_load_s | bus.in_valid) & ~bus.clear;
      ready_s    = bus.advance & any_load_s & ~bus.clear;
   end

   assign bus.in_ready = ready_s;

   // Next delay-line contents: shift toward the head, tail takes input or head.
   always_comb begin
      mem_d = mem_q;
      if (bus.clear) begin
         for (int l = 0; l < NB_LANES; l++) begin
            for (int r = 0; r < KERNEL_SIZE; r++) begin
               for (int e = 0; e < DEPTH; e++) begin
                  mem_d[l][r][e] = '0;
               end
            end
         end
      end else if (step_s) begin
         for (int l = 0; l < NB_LANES; l++) begin
            for (int r = 0; r < KERNEL_SIZE; r++) begin
               for (int e = 0; e < DEPTH - 1; e++) begin
                  mem_d[l][r][e] = mem_q[l][r][e+1];
               end
               if (bus.lane_load[l]) begin
                  mem_d[l][r][DEPTH-1] = bus.in_data[r*DATA_WIDTH +: DATA_WIDTH];
               end else begin
                  mem_d[l][r][DEPTH-1] = mem_q[l][r][0];
               end
            end
         end
      end else begin
         mem_d = mem_q;
      end
   end

   // Delay-line storage.
   always_ff @(posedge clk or posedge arst_in) begin
      if (arst_in) begin
         for (int l = 0; l < NB_LANES; l++) begin
            for (int r = 0; r < KERNEL_SIZE; r++) begin
               for (int e = 0; e < DEPTH; e++) begin
                  mem_q[l][r][e] <= '0;
               end
            end
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   // Lane fill state machine; out_valid is registered alongside the state.
   always_ff @(posedge clk or posedge arst_in) begin
      if (arst_in) begin
         for (int l = 0; l < NB_LANES; l++) begin
            lane_st_q[l] <= LANE_EMPTY;
            fill_q[l]    <= '0;
         end
         out_valid_q <= '0;
      end else if (bus.clear) begin
         for (int l = 0; l < NB_LANES; l++) begin
            lane_st_q[l] <= LANE_EMPTY;
            fill_q[l]    <= '0;
         end
         out_valid_q <= '0;
      end else if (step_s) begin
         for (int l = 0; l < NB_LANES; l++) begin
            if (bus.lane_load[l]) begin
               case (lane_st_q[l])
                  LANE_EMPTY: begin
                     lane_st_q[l] <= LANE_FILLING;
                     fill_q[l]    <= FILL_ONE;
                  end
                  LANE_FILLING: begin
                     fill_q[l] <= fill_q[l] + FILL_ONE;
                     if (fill_q[l] == (FILL_FULL - FILL_ONE)) begin
                        lane_st_q[l]   <= LANE_FULL;
                        out_valid_q[l] <= 1'b1;
                     end
                  end
                  LANE_FULL: begin
                     fill_q[l]      <= FILL_FULL;
                     out_valid_q[l] <= 1'b1;
                  end
                  default: begin
                     lane_st_q[l]   <= LANE_EMPTY;
                     fill_q[l]      <= '0;
                     out_valid_q[l] <= 1'b0;
                  end
               endcase
            end
         end
      end
   end

   // Rotation counter next state; wrap flags the step leaving DEPTH-1.
   always_comb begin
      rot_count_d = rot_count_q;
      rot_wrap_d  = 1'b0;
      if (bus.clear) begin
         rot_count_d = '0;
         rot_wrap_d  = 1'b0;
      end else if (step_s) begin
         rot_count_d = rot_count_q + ROT_W'(1);
         rot_wrap_d  = (rot_count_q == {ROT_W{1'b1}});
      end else begin
         rot_count_d = rot_count_q;
         rot_wrap_d  = 1'b0;
      end
   end

   // Rotation counter and wrap pulse registers.
   always_ff @(posedge clk or posedge arst_in) begin
      if (arst_in) begin
         rot_count_q <= '0;
         rot_wrap_q  <= 1'b0;
      end else begin
         rot_count_q <= rot_count_d;
         rot_wrap_q  <= rot_wrap_d;
      end
   end

   // Flatten the head entries of every lane/row onto the output bus.
   always_comb begin
      out_data_s = '0;
      for (int l = 0; l < NB_LANES; l++) begin
         for (int r = 0; r < KERNEL_SIZE; r++) begin
            out_data_s[(l*KERNEL_SIZE+r)*DATA_WIDTH +: DATA_WIDTH] = mem_q[l][r][0];
         end
      end
   end

   assign bus.out_data  = out_data_s;
   assign bus.out_valid = out_valid_q;
   assign bus.rot_count = rot_count_q;
   assign bus.rot_wrap  = rot_wrap_q;
endmodule

// File: tb/tb_kds_multilane.sv
// Bench for kds_multilane: directed scenarios plus a random phase, all
// checked against a queue-per-lane column model.
module tb_kds_multilane;
   localparam int DW = 16;
   localparam int KS = 3;
   localparam int NL = 12;
   localparam int DP = 8;
   localparam int CW = KS * DW;
   localparam int BW = NL * CW;

   logic clk = 1'b0;
   logic arst_in;
   int   checks = 0;
   int   errors = 0;

   kds_multilane_if #(.DATA_WIDTH(DW), .KERNEL_SIZE(KS), .NB_LANES(NL), .DEPTH(DP)) bus();

   kds_multilane #(.DATA_WIDTH(DW), .KERNEL_SIZE(KS), .NB_LANES(NL), .DEPTH(DP)) dut (
      .clk     (clk),
      .arst_in (arst_in),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;

   // Model: each lane is a queue of whole columns, front = head.
   logic [CW-1:0] mdl [NL][$];
   int            mfill [NL];
   int            msteps;
   bit            mwrap;

   function automatic logic [CW-1:0] col3(input int a, input int b, input int c);
      return {16'(c), 16'(b), 16'(a)};
   endfunction

   task automatic model_reset();
      for (int l = 0; l < NL; l++) begin
         mdl[l].delete();
         for (int k = 0; k < DP; k++) mdl[l].push_back('0);
         mfill[l] = 0;
      end
      msteps = 0;
      mwrap  = 1'b0;
   endtask

   task automatic model_edge(input logic [CW-1:0] d, input logic [NL-1:0] ld,
                             input bit adv, input bit vld, input bit clr);
      logic [CW-1:0] col;
      bit step;
      if (clr) begin
         model_reset();
      end else begin
         step  = adv && ((ld == '0) || vld);
         mwrap = 1'b0;
         if (step) begin
            for (int l = 0; l < NL; l++) begin
               col = mdl[l].pop_front();
               mdl[l].push_back(ld[l] ? d : col);
               if (ld[l] && mfill[l] < DP) mfill[l]++;
            end
            msteps = (msteps + 1) % DP;
            mwrap  = (msteps == 0);
         end
      end
   endtask

   task automatic check_eq(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [BW-1:0] exp_data;
      logic [NL-1:0] exp_valid;
      logic [CW-1:0] head;
      for (int l = 0; l < NL; l++) begin
         head = mdl[l][0];
         exp_data[l*CW +: CW] = head;
         exp_valid[l] = (mfill[l] == DP);
      end
      check_eq({tag, ".out_data"},  bus.out_data, exp_data);
      check_eq({tag, ".out_valid"}, BW'(bus.out_valid), BW'(exp_valid));
      check_eq({tag, ".rot_count"}, BW'(bus.rot_count), BW'(msteps));
      check_eq({tag, ".rot_wrap"},  BW'(bus.rot_wrap), BW'(mwrap));
   endtask

   // One clock: drive inputs, check in_ready, clock, update model, check outputs.
   task automatic do_cycle(input logic [CW-1:0] d, input logic [NL-1:0] ld,
                           input bit adv, input bit vld, input bit clr, input string tag);
      bus.in_data   = d;
      bus.lane_load = ld;
      bus.advance   = adv;
      bus.in_valid  = vld;
      bus.clear     = clr;
      #1;
      check_eq({tag, ".in_ready"}, BW'(bus.in_ready), BW'(adv && (ld != '0) && !clr));
      @(posedge clk);
      model_edge(d, ld, adv, vld, clr);
      #1;
      check_outputs(tag);
   endtask

   function automatic logic [CW-1:0] rnd_col();
      return CW'({$urandom(), $urandom()});
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with random inputs, advance low.
      arst_in       = 1'b1;
      bus.in_data   = rnd_col();
      bus.lane_load = NL'($urandom());
      bus.in_valid  = 1'($urandom());
      bus.clear     = 1'($urandom());
      bus.advance   = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset");
      check_eq("reset.in_ready", BW'(bus.in_ready), BW'(0));
      #2 arst_in = 1'b0;
      @(posedge clk);
      #1;

      // Fill lane 0 with (k,100+k,200+k).
      for (int k = 1; k <= DP; k++) do_cycle(col3(k, 100 + k, 200 + k), 12'h001, 1'b1, 1'b1, 1'b0, "fill0");
      check_eq("fill0.head", BW'(bus.out_data[CW-1:0]), BW'(col3(1, 101, 201)));
      check_eq("fill0.valid", BW'(bus.out_valid), BW'(12'h001));
      check_eq("fill0.wrap", BW'(bus.rot_wrap), BW'(1));
      check_eq("fill0.others", BW'(bus.out_data[BW-1:CW]), BW'(0));

      // Recirculate for a full period; head walks 2..8 then back to 1.
      for (int i = 1; i <= DP; i++) begin
         do_cycle(rnd_col(), 12'h000, 1'b1, 1'($urandom()), 1'b0, "recirc");
         check_eq("recirc.head", BW'(bus.out_data[DW-1:0]), BW'((i % DP) + 1));
      end
      check_eq("recirc.valid", BW'(bus.out_valid), BW'(12'h001));

      // Handshake stall: ready but no data, then one transfer.
      for (int i = 0; i < 3; i++) begin
         do_cycle(rnd_col(), 12'h001, 1'b1, 1'b0, 1'b0, "stall");
         check_eq("stall.rot", BW'(bus.rot_count), BW'(0));
      end
      do_cycle(col3(9, 109, 209), 12'h001, 1'b1, 1'b1, 1'b0, "stall_go");
      check_eq("stall_go.rot", BW'(bus.rot_count), BW'(1));

      // Mixed load on odd lanes.
      for (int k = 0; k < DP; k++) do_cycle(col3(5, 6, 7), 12'hAAA, 1'b1, 1'b1, 1'b0, "mixed");
      check_eq("mixed.valid", BW'(bus.out_valid & 12'hAAA), BW'(12'hAAA));
      for (int k = 0; k < DP; k++) begin
         do_cycle(rnd_col(), 12'h000, 1'b1, 1'b1, 1'b0, "mixed_rc");
         check_eq("mixed_rc.lane1", BW'(bus.out_data[CW +: CW]), BW'(col3(5, 6, 7)));
      end

      // Clear together with advance during a fill.
      for (int k = 0; k < 3; k++) do_cycle(rnd_col(), 12'h020, 1'b1, 1'b1, 1'b0, "pre_clr");
      do_cycle(rnd_col(), 12'h020, 1'b1, 1'b1, 1'b1, "clear");
      check_eq("clear.data", bus.out_data, BW'(0));
      check_eq("clear.rot", BW'(bus.rot_count), BW'(0));
      check_eq("clear.valid", BW'(bus.out_valid), BW'(0));

      // Random phase.
      for (int i = 0; i < 300; i++) begin
         do_cycle(rnd_col(), NL'($urandom()) & NL'($urandom()), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 3) != 0), ($urandom_range(0, 24) == 0), "random");
      end

      // Async reset in the middle of recirculation.
      for (int k = 0; k < DP; k++) do_cycle(rnd_col(), 12'h004, 1'b1, 1'b1, 1'b0, "fill2");
      for (int k = 0; k < 3; k++) do_cycle(rnd_col(), 12'h000, 1'b1, 1'b1, 1'b0, "rc2");
      #2 arst_in = 1'b1;
      #1;
      model_reset();
      check_outputs("arst_mid");
      check_eq("arst_mid.data", bus.out_data, BW'(0));
      bus.advance = 1'b1;
      @(posedge clk);
      #1;
      check_outputs("arst_hold");
      #2 arst_in = 1'b0;
      for (int k = 1; k <= DP; k++) do_cycle(col3(k, 2 * k, 3 * k), 12'h004, 1'b1, 1'b1, 1'b0, "refill");
      check_eq("refill.valid", BW'(bus.out_valid), BW'(12'h004));
      check_eq("refill.wrap", BW'(bus.rot_wrap), BW'(1));
      check_eq("refill.head", BW'(bus.out_data[2*CW +: CW]), BW'(col3(1, 2, 3)));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
